iram_boot: RTL and testbench

Parametrised instruction memory with a byte-stream boot loader, replacing a fixed reset-initialised program ROM. The CPU fetch port reads combinationally by byte address. A loader port accepts program bytes over a valid/ready handshake, packs them big-endian into words and writes them sequentially from word 0. Unused words are zero-filled. BUSY stalls the CPU while contents are being changed.

---
 rtl/iram_boot.sv | 201 ++++++++++++++++++++
 tb/tb_iram_boot.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_boot.sv
// -----------------------------------------------------------------------------
// iram_boot : instruction RAM with byte-stream boot loader
//
// After reset the whole array is swept to zero (CLEAR). A load (LD_START in
// IDLE) accepts program bytes over LD_VALID/LD_READY, packs them big-endian
// into DATA_W-bit words written from word 0 upward, then zero-fills the
// remaining words (FILL). BUSY is high for every sweep so the CPU stalls
// while contents change.
//
// Ports
//   CLK       clock, all state changes on the rising edge
//   RESET     asynchronous, active-high reset
//   ADDR      CPU fetch byte address (low byte-offset bits ignored)
//   Q         combinational instruction word at ADDR (0 when out of range)
//   BUSY      clear/load/fill sweep in progress, CPU must stall
//   LD_START  one-cycle load request, honoured only in IDLE
//   LD_VALID  LD_DATA valid
//   LD_DATA   program byte
//   LD_LAST   final byte of the program, qualified by LD_VALID
//   LD_READY  loader can accept a byte
//   LD_DONE   one-cycle pulse when a load (and its fill) completes
//   LD_ERR    last load overflowed capacity, held until the next LD_START
// -----------------------------------------------------------------------------
module iram_boot #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  output logic              BUSY,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [7:0]        LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              LD_DONE,
  output logic              LD_ERR
);

  localparam int BPW   = DATA_W / 8;
  localparam int OFF_W = $clog2(BPW);
  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so the pointer can hold DEPTH, meaning "array full".
  localparam int PTR_W = IDX_W + 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(DEPTH);
  localparam logic [OFF_W-1:0] LANE_LAST = OFF_W'(BPW - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD, S_FILL} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [OFF_W-1:0]   bcnt_q, bcnt_d;
  logic [DATA_W-1:0]  asm_q, asm_d, merged;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [DATA_W-1:0]  wr_data;

  logic [DATA_W-1:0]  mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Fetch port
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rd_idx;
  logic             rd_hit;

  assign rd_idx = ADDR[OFF_W +: IDX_W];
  // Any set bit above the word index means the address is past the array.
  assign rd_hit = (ADDR >> (OFF_W + IDX_W)) == '0;
  assign Q      = rd_hit ? mem[rd_idx] : '0;

  assign BUSY     = busy_q;
  assign LD_READY = ready_q;
  assign LD_DONE  = done_q;
  assign LD_ERR   = err_q;

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q[IDX_W-1:0];
    wr_data = '0;
    ptr_inc = ptr_q + PTR_W'(1);
    // Incoming byte dropped into lane bcnt; lane 0 is the MSB.
    merged  = asm_q | (DATA_W'(LD_DATA) << ((BPW - 1 - int'(bcnt_q)) * 8));

    case (state_q)
      S_CLEAR, S_FILL: begin
        wr_en = 1'b1;
        ptr_d = ptr_inc;
        if (ptr_q == PTR_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = (state_q == S_FILL);
        end
      end

      S_IDLE: begin
        if (LD_START) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          bcnt_d  = '0;
          asm_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b1;
        end
      end

      S_LOAD: begin
        if (LD_VALID && ready_q) begin
          if (ptr_q == PTR_FULL) begin
            ovf_d = 1'b1;
          end else if (bcnt_q == LANE_LAST || LD_LAST) begin
            wr_en   = 1'b1;
            wr_data = merged;
            ptr_d   = ptr_inc;
            bcnt_d  = '0;
            asm_d   = '0;
          end else begin
            asm_d  = merged;
            bcnt_d = bcnt_q + OFF_W'(1);
          end

          if (LD_LAST) begin
            ready_d = 1'b0;
            if (ptr_d < PTR_FULL) begin
              state_d = S_FILL;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              err_d   = ovf_d;
            end
          end
        end
      end

      default: state_d = S_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array has no reset; the CLEAR sweep zeroes it after reset so it
  // maps onto plain RAM without a per-bit reset network.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_iram_boot.sv
// -----------------------------------------------------------------------------
// tb_iram_boot : self-checking bench for iram_boot
//
// Instance a: DATA_W=16, DEPTH=128, ADDR_W=8 (main scenarios, random streams).
// Instance b: DATA_W=32, DEPTH=16,  ADDR_W=7 (wide words, out-of-range fetch).
// Expected memory images come from a flat byte list packed big-endian into
// words, with missing bytes reading as zero and bytes past capacity dropped.
// -----------------------------------------------------------------------------
module tb_iram_boot;

  localparam int DW_A = 16, DP_A = 128, AW_A = 8, BPW_A = 2;
  localparam int DW_B = 32, DP_B = 16,  AW_B = 7;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            a_reset, a_busy, a_start, a_valid, a_last, a_ready, a_done, a_err;
  logic [AW_A-1:0] a_addr;
  logic [DW_A-1:0] a_q;
  logic [7:0]      a_data;

  logic            b_reset, b_busy, b_start, b_valid, b_last, b_ready, b_done, b_err;
  logic [AW_B-1:0] b_addr;
  logic [DW_B-1:0] b_q;
  logic [7:0]      b_data;

  iram_boot #(.DATA_W(DW_A), .DEPTH(DP_A), .ADDR_W(AW_A)) dut_a (
    .CLK(CLK), .RESET(a_reset), .ADDR(a_addr), .Q(a_q), .BUSY(a_busy),
    .LD_START(a_start), .LD_VALID(a_valid), .LD_DATA(a_data), .LD_LAST(a_last),
    .LD_READY(a_ready), .LD_DONE(a_done), .LD_ERR(a_err)
  );

  iram_boot #(.DATA_W(DW_B), .DEPTH(DP_B), .ADDR_W(AW_B)) dut_b (
    .CLK(CLK), .RESET(b_reset), .ADDR(b_addr), .Q(b_q), .BUSY(b_busy),
    .LD_START(b_start), .LD_VALID(b_valid), .LD_DATA(b_data), .LD_LAST(b_last),
    .LD_READY(b_ready), .LD_DONE(b_done), .LD_ERR(b_err)
  );

  int n_total = 0, n_pass = 0, n_fail = 0;
  int done_a = 0, done_busy_a = 0, done_b = 0;
  logic [7:0] bq[$];
  logic [7:0] bqb[$];

  // Count LD_DONE pulses (and any with BUSY still high) mid-cycle.
  always @(negedge CLK) begin
    if (a_done) begin
      done_a++;
      if (a_busy) done_busy_a++;
    end
    if (b_done) done_b++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference image of instance a: word i holds stream bytes i*BPW .. i*BPW+BPW-1.
  function automatic logic [31:0] exp_word_a(input int i);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < BPW_A; b++) begin
      int k;
      k = i * BPW_A + b;
      w = (w << 8) | ((k < bq.size()) ? 32'(bq[k]) : 32'h0);
    end
    return w;
  endfunction

  task automatic readback_a(input string tag);
    for (int i = 0; i < DP_A; i++) begin
      a_addr = AW_A'(i * BPW_A + int'($urandom_range(BPW_A - 1)));
      #1;
      check($sformatf("%s_w%0d", tag, i), 32'(a_q), exp_word_a(i));
    end
    tick();
  endtask

  task automatic wait_clear_a(input string tag);
    int c;
    c = 0;
    while (a_busy && c < 4 * DP_A) begin
      tick();
      c++;
    end
    check({tag, "_busy_cycles"}, 32'(c), 32'(DP_A));
    check({tag, "_ready"}, 32'(a_ready), 32'(0));
    check({tag, "_err"}, 32'(a_err), 32'(0));
  endtask

  // Sends the stream held in bq, optionally with valid gaps and stray LD_START.
  task automatic run_load_a(input string tag, input int gap_pct, input bit noise);
    int n, words, fill, c, not_ready, done0;
    bit ovf;
    n     = bq.size();
    words = (n + BPW_A - 1) / BPW_A;
    if (words > DP_A) words = DP_A;
    ovf   = (n > DP_A * BPW_A);
    fill  = DP_A - words;
    done0 = done_a;

    // A byte presented together with LD_START in IDLE must not be taken.
    a_start = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'($urandom);
    a_last  = 1'($urandom);
    tick();
    a_start = 1'b0;
    check({tag, "_start_busy"}, 32'(a_busy), 32'(1));
    check({tag, "_start_ready"}, 32'(a_ready), 32'(1));
    check({tag, "_start_err"}, 32'(a_err), 32'(0));

    not_ready = 0;
    for (int i = 0; i < n;) begin
      a_start = noise ? 1'($urandom_range(1)) : 1'b0;
      if (int'($urandom_range(99)) < gap_pct) begin
        a_valid = 1'b0;
        a_data  = 8'($urandom);
        a_last  = 1'($urandom);
      end else begin
        a_valid = 1'b1;
        a_data  = bq[i];
        a_last  = (i == n - 1);
        if (!a_ready) not_ready++;
        i++;
      end
      tick();
    end
    a_valid = 1'b0;
    a_last  = 1'b0;

    c = 0;
    while (a_busy && c < 4 * DP_A) begin
      a_start = noise ? 1'($urandom_range(1)) : 1'b0;
      tick();
      c++;
    end
    a_start = 1'b0;
    check({tag, "_fill_cycles"}, 32'(c), 32'(fill));
    check({tag, "_done_pulse"}, 32'(a_done), 32'(1));
    check({tag, "_err"}, 32'(a_err), 32'(ovf));
    check({tag, "_ready_off"}, 32'(a_ready), 32'(0));
    tick();
    check({tag, "_done_once"}, 32'(a_done), 32'(0));
    check({tag, "_done_count"}, 32'(done_a - done0), 32'(1));
    check({tag, "_ready_in_load"}, 32'(not_ready), 32'(0));
  endtask

  task automatic run_load_b(input string tag);
    int c, fill;
    fill = DP_B - (bqb.size() + 3) / 4;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < bqb.size(); i++) begin
      b_valid = 1'b1;
      b_data  = bqb[i];
      b_last  = (i == bqb.size() - 1);
      tick();
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
    c = 0;
    while (b_busy && c < 4 * DP_B) begin
      tick();
      c++;
    end
    check({tag, "_fill_cycles"}, 32'(c), 32'(fill));
    check({tag, "_done_pulse"}, 32'(b_done), 32'(1));
    check({tag, "_err"}, 32'(b_err), 32'(0));
  endtask

  task automatic probe_b(input string tag, input int addr, input logic [31:0] exp);
    b_addr = AW_B'(addr);
    #1;
    check($sformatf("%s_a%0d", tag, addr), b_q, exp);
  endtask

  initial begin
    int c, done0;
    a_reset = 1'b1; a_addr = '0; a_start = 1'b0; a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_reset = 1'b1; b_addr = '0; b_start = 1'b0; b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    tick();
    tick();
    check("reset_busy", 32'(a_busy), 32'(1));
    check("reset_ready", 32'(a_ready), 32'(0));
    check("reset_done", 32'(a_done), 32'(0));

    // Step 1: power-up clear sweep.
    a_reset = 1'b0;
    wait_clear_a("clear");
    bq.delete();
    readback_a("clear");
    check("clear_no_done", 32'(done_a), 32'(0));

    // Step 2: two-word program, 126-cycle fill.
    bq = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load_a("load4", 0, 1'b0);
    readback_a("load4");

    // Step 3: fill every word with FF exactly to capacity (no FILL, no error).
    bq.delete();
    for (int i = 0; i < DP_A * BPW_A; i++) bq.push_back(8'hFF);
    run_load_a("preload", 0, 1'b0);
    readback_a("preload");

    // Step 4: odd-length program overwrites the FF image with padding and zeros.
    bq = '{8'hAB, 8'hCD, 8'hEF};
    run_load_a("load3", 0, 1'b0);
    readback_a("load3");

    // Step 5: overflow by two bytes.
    bq.delete();
    for (int i = 0; i < DP_A * BPW_A + 2; i++) bq.push_back(8'($urandom));
    run_load_a("ovf", 0, 1'b0);
    readback_a("ovf");
    tick();
    tick();
    check("ovf_err_held", 32'(a_err), 32'(1));

    // Step 6: the same short stream with gaps and stray LD_START pulses.
    bq = '{8'hAB, 8'hCD, 8'hEF};
    run_load_a("gap3", 40, 1'b1);
    readback_a("gap3");

    // Step 7: random streams with gaps and noise.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = int'($urandom_range(DP_A * BPW_A + 4, 1));
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      run_load_a($sformatf("rnd%0d", r), 30, 1'b1);
      readback_a($sformatf("rnd%0d", r));
    end

    // Step 8: reset in the middle of a load.
    done0 = done_a;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1;
      a_data  = 8'($urandom);
      a_last  = 1'b0;
      tick();
    end
    a_valid = 1'b0;
    #3 a_reset = 1'b1;
    #1;
    check("midrst_busy", 32'(a_busy), 32'(1));
    check("midrst_ready", 32'(a_ready), 32'(0));
    tick();
    tick();
    a_reset = 1'b0;
    wait_clear_a("midrst");
    bq.delete();
    readback_a("midrst");
    check("midrst_no_done", 32'(done_a - done0), 32'(0));
    check("done_busy_low", 32'(done_busy_a), 32'(0));

    // Step 9: 32-bit instance.
    b_reset = 1'b0;
    c = 0;
    while (b_busy && c < 4 * DP_B) begin
      tick();
      c++;
    end
    check("b_clear_cycles", 32'(c), 32'(DP_B));
    check("b_clear_ready", 32'(b_ready), 32'(0));
    bqb = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load_b("b4");
    probe_b("b4", 0, 32'h11223344);
    probe_b("b4", 3, 32'h11223344);
    probe_b("b4", 4, 32'h00000000);
    probe_b("b4", 64, 32'h00000000);
    probe_b("b4", 127, 32'h00000000);
    tick();
    bqb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load_b("b5");
    probe_b("b5", 1, 32'hAABBCCDD);
    probe_b("b5", 6, 32'hEE000000);
    probe_b("b5", 8, 32'h00000000);
    probe_b("b5", 67, 32'h00000000);
    probe_b("b5", 68, 32'h00000000);
    check("b_done_count", 32'(done_b), 32'(2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
